// File: rtl/uart_tx_sink_if.sv
// Valid/ready byte-stream interface between the MMIO store path and the UART sink.
// The producer drives valid and data; the consumer answers with ready.
interface rv_if #(
   parameter int DW = 8
);
   logic          valid;
   logic          ready;
   logic [DW-1:0] data;

   modport TX (output valid, output data, input  ready);
   modport RX (input  valid, input  data, output ready);
endinterface

// File: rtl/uart_tx_sink.sv
// Byte-stream sink: a small FIFO feeding an 8N1 UART serialiser, sent LSB first.
// uart_tx always comes straight from a flop and idles high.
module uart_tx_sink #(
   parameter  int CLKS_PER_BIT = 16,
   parameter  int FIFO_DEPTH   = 4,
   localparam int CW           = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   rv_if.RX              byte_in,
   output logic          uart_tx,
   output logic          busy,
   output logic [CW-1:0] fifo_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_reg, state_next;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]   cnt_reg;
   logic [7:0]      shift_reg, shift_next;
   logic [BW-1:0]   baud_cnt_reg, baud_cnt_next;
   logic [2:0]      bit_cnt_reg, bit_cnt_next;
   logic            tx_reg, tx_next;
   logic            push, pop, fifo_empty, baud_done;

   // Ready comes only from the registered count, so a full FIFO refuses even while popping.
   assign byte_in.ready = (cnt_reg != CW'(FIFO_DEPTH));
   assign push          = byte_in.valid && byte_in.ready;
   assign fifo_empty    = (cnt_reg == '0);
   assign baud_done     = (baud_cnt_reg == BW'(CLKS_PER_BIT - 1));
   assign uart_tx       = tx_reg;
   assign busy          = (state_reg != IDLE) || (cnt_reg != '0);
   assign fifo_cnt      = cnt_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= byte_in.data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   cnt_reg <= cnt_reg + 1'b1;
            2'b01:   cnt_reg <= cnt_reg - 1'b1;
            default: cnt_reg <= cnt_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         shift_reg    <= '0;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         tx_reg       <= 1'b1;
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         tx_reg       <= tx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (!fifo_empty) state_next = START;
         START:   if (baud_done) state_next = DATA;
         DATA:    if (baud_done && bit_cnt_reg == 3'd7) state_next = STOP;
         STOP:    if (baud_done) state_next = fifo_empty ? IDLE : START;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pop           = 1'b0;
      tx_next       = tx_reg;
      shift_next    = shift_reg;
      bit_cnt_next  = bit_cnt_reg;
      baud_cnt_next = baud_done ? '0 : baud_cnt_reg + 1'b1;
      case (state_reg)
         IDLE: begin
            baud_cnt_next = '0;
            bit_cnt_next  = '0;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = mem[rd_ptr_reg];
               tx_next    = 1'b0;
            end
         end
         START: begin
            if (baud_done) begin
               tx_next      = shift_reg[0];
               bit_cnt_next = '0;
            end
         end
         DATA: begin
            if (baud_done) begin
               if (bit_cnt_reg == 3'd7) begin
                  tx_next = 1'b1;
               end else begin
                  shift_next   = {1'b0, shift_reg[7:1]};
                  tx_next      = shift_reg[1];
                  bit_cnt_next = bit_cnt_reg + 1'b1;
               end
            end
         end
         STOP: begin
            // Chain straight into the next start bit so queued bytes leave no idle gap.
            if (baud_done) begin
               bit_cnt_next = '0;
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  shift_next = mem[rd_ptr_reg];
                  tx_next    = 1'b0;
               end
            end
         end
         default: begin
            tx_next = 1'b1;
         end
      endcase
   end
endmodule
